// File: rtl/uart_frame_parser.sv
// uart_frame_parser: turns the UART receiver's byte stream into HEADER/CMD/LEN/payload/CHK frames.
// Latency: Frame_valid/Frame_err are registered, so they are high in the cycle after the edge that consumes the last byte.
// Backpressure: none. Every byte is consumed on its strobe, and a gap longer than the timeout aborts the frame.
//
// Ports:
//   i_clk, i_reset        system clock (rising edge); asynchronous active-high reset
//   i_rx_data, i_rx_done  received byte; level done flag whose rising edge marks a new byte
//   o_frame_valid         one-cycle pulse when a good frame appears on o_frame_cmd/len/payload
//   o_frame_cmd/len       CMD and LEN of the last good frame
//   o_frame_payload       payload, with byte i at [8i+7:8i] and bytes >= LEN zero
//   o_frame_err           one-cycle pulse when a frame is aborted
//   o_err_code            1 = LEN too large, 2 = bad checksum, 3 = timeout; holds until the next error
//   o_busy                high while a frame is in progress
module uart_frame_parser #(
   parameter int         MCNT          = 50_000_000,
   parameter int         BAUD          = 9600,
   parameter int         MAX_LEN       = 8,
   parameter logic [7:0] HEADER        = 8'hAA,
   parameter int         TIMEOUT_BYTES = 20
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [7:0]             i_rx_data,
   input  logic                   i_rx_done,
   output logic                   o_frame_valid,
   output logic [7:0]             o_frame_cmd,
   output logic [3:0]             o_frame_len,
   output logic [8*MAX_LEN-1:0]   o_frame_payload,
   output logic                   o_frame_err,
   output logic [1:0]             o_err_code,
   output logic                   o_busy
);

   localparam int BIT_CYC     = MCNT / BAUD;
   localparam int TIMEOUT_CYC = TIMEOUT_BYTES * 10 * BIT_CYC;
   localparam int TW          = $clog2(TIMEOUT_CYC + 1);
   localparam int IW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_DATA, S_CHK} state_t;

   state_t          r_state;
   logic            r_rx_done_d;
   logic [TW-1:0]   r_timer;
   logic [7:0]      r_cmd;
   logic [3:0]      r_len;
   logic [3:0]      r_idx;
   logic [7:0]      r_chk;
   logic [7:0]      r_buf [MAX_LEN];

   logic            w_stb;
   logic            w_timeout;

   // r_rx_done_d resets to 1, so a done level that is already high when reset is released is not taken as a new byte.
   assign w_stb     = i_rx_done & ~r_rx_done_d;
   // If a byte arrives in the limit cycle, the byte takes priority and the timeout does not fire.
   assign w_timeout = (r_state != S_IDLE) && !w_stb && (r_timer == TW'(TIMEOUT_CYC - 1));
   assign o_busy    = (r_state != S_IDLE);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state         <= S_IDLE;
         r_rx_done_d     <= 1'b1;
         r_timer         <= '0;
         r_cmd           <= '0;
         r_len           <= '0;
         r_idx           <= '0;
         r_chk           <= '0;
         for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= '0;
         o_frame_valid   <= 1'b0;
         o_frame_cmd     <= '0;
         o_frame_len     <= '0;
         o_frame_payload <= '0;
         o_frame_err     <= 1'b0;
         o_err_code      <= '0;
      end else begin
         r_rx_done_d   <= i_rx_done;
         o_frame_valid <= 1'b0;
         o_frame_err   <= 1'b0;

         if (r_state == S_IDLE || w_stb) r_timer <= '0;
         else                            r_timer <= r_timer + TW'(1);

         if (w_timeout) begin
            o_frame_err <= 1'b1;
            o_err_code  <= 2'd3;
            r_state     <= S_IDLE;
            r_timer     <= '0;
         end else if (w_stb) begin
            case (r_state)
               S_IDLE: begin
                  // Bytes other than HEADER are dropped silently while waiting for a frame.
                  if (i_rx_data == HEADER) r_state <= S_CMD;
               end
               S_CMD: begin
                  r_cmd   <= i_rx_data;
                  r_chk   <= i_rx_data;
                  // Clear the buffer here so that payload bytes beyond LEN read back as zero.
                  for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= '0;
                  r_state <= S_LEN;
               end
               S_LEN: begin
                  if (i_rx_data > 8'(MAX_LEN)) begin
                     o_frame_err <= 1'b1;
                     o_err_code  <= 2'd1;
                     r_state     <= S_IDLE;
                  end else begin
                     r_len   <= i_rx_data[3:0];
                     r_idx   <= '0;
                     r_chk   <= r_chk ^ i_rx_data;
                     r_state <= (i_rx_data == 8'd0) ? S_CHK : S_DATA;
                  end
               end
               S_DATA: begin
                  r_buf[r_idx[IW-1:0]] <= i_rx_data;
                  r_chk                <= r_chk ^ i_rx_data;
                  r_idx                <= r_idx + 4'd1;
                  if (r_idx == r_len - 4'd1) r_state <= S_CHK;
               end
               S_CHK: begin
                  if (i_rx_data == r_chk) begin
                     o_frame_valid <= 1'b1;
                     o_frame_cmd   <= r_cmd;
                     o_frame_len   <= r_len;
                     for (int i = 0; i < MAX_LEN; i++) o_frame_payload[8*i +: 8] <= r_buf[i];
                  end else begin
                     o_frame_err <= 1'b1;
                     o_err_code  <= 2'd2;
                  end
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser. It sends directed and random frames and checks
// the result of each frame against a frame-level model built from the generated bytes.
module tb_uart_frame_parser;
   localparam int MAX_LEN = 8;
   localparam int PW      = 8 * MAX_LEN;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_done = 1'b0;
   logic          frame_valid, frame_err, busy;
   logic [7:0]    frame_cmd;
   logic [3:0]    frame_len;
   logic [PW-1:0] frame_payload;
   logic [1:0]    err_code;

   uart_frame_parser #(
      .MCNT(1000), .BAUD(100), .MAX_LEN(MAX_LEN), .HEADER(8'hAA), .TIMEOUT_BYTES(2)
   ) dut (
      .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
      .o_frame_valid(frame_valid), .o_frame_cmd(frame_cmd), .o_frame_len(frame_len),
      .o_frame_payload(frame_payload), .o_frame_err(frame_err), .o_err_code(err_code),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Each high cycle of either pulse is logged, so a pulse that lasts two cycles shows up as two events.
   typedef struct {
      bit            is_err;
      logic [1:0]    code;
      int            cyc;
   } ev_t;
   ev_t ev_q[$];

   always @(negedge clk) begin
      if (!rst && (frame_valid || frame_err)) begin
         ev_t e;
         e.is_err = frame_err;
         e.code   = err_code;
         e.cyc    = cyc;
         ev_q.push_back(e);
         check("excl", {63'd0, frame_valid & frame_err}, 64'd0);
      end
   end

   // Model state: contents of the last good frame and the last error code reported.
   logic [7:0]    m_cmd  = 8'h00;
   logic [3:0]    m_len  = 4'h0;
   logic [PW-1:0] m_pl   = '0;
   logic [1:0]    m_code = 2'd0;
   int            last_stb = 0;

   // Caller is at #1 after a posedge with rx_done low for at least one edge.
   task automatic send_byte(input logic [7:0] b);
      int hold = $urandom_range(1, 4);
      int gap  = $urandom_range(1, 6);
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk); #1;
      last_stb = cyc;
      repeat (hold - 1) begin @(posedge clk); #1; end
      rx_done = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic check_held(input string tag);
      check({tag, "_cmd"},  frame_cmd, m_cmd);
      check({tag, "_len"},  frame_len, m_len);
      check({tag, "_pl"},   frame_payload, m_pl);
      check({tag, "_code"}, err_code, m_code);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic expect_good(input string tag, input logic [7:0] cmd, input logic [3:0] len,
                              input logic [PW-1:0] pl);
      ev_t e;
      @(posedge clk); #1;
      check({tag, "_nev"}, ev_q.size(), 1);
      if (ev_q.size() > 0) begin
         e = ev_q.pop_front();
         check({tag, "_kind"}, e.is_err, 0);
         check({tag, "_lat"}, e.cyc - last_stb, 0);
      end
      m_cmd = cmd; m_len = len; m_pl = pl;
      check_held(tag);
      ev_q.delete();
   endtask

   task automatic expect_err(input string tag, input logic [1:0] code);
      ev_t e;
      @(posedge clk); #1;
      check({tag, "_nev"}, ev_q.size(), 1);
      if (ev_q.size() > 0) begin
         e = ev_q.pop_front();
         check({tag, "_kind"}, e.is_err, 1);
         check({tag, "_ecode"}, e.code, code);
         check({tag, "_lat"}, e.cyc - last_stb, 0);
      end
      m_code = code;
      check_held(tag);
      ev_q.delete();
   endtask

   // kind 0: good frame, 1: bad checksum, 2: LEN too large, 3: good frame preceded by junk bytes
   task automatic random_frame(input int kind);
      logic [7:0]    cmd = 8'($urandom);
      logic [7:0]    len = 8'($urandom_range(0, MAX_LEN));
      logic [7:0]    chk;
      logic [7:0]    b;
      logic [PW-1:0] pl = '0;
      int            njunk;
      if (kind == 2) len = 8'($urandom_range(MAX_LEN + 1, 255));
      if (kind == 3) begin
         njunk = $urandom_range(1, 3);
         for (int j = 0; j < njunk; j++) begin
            b = 8'($urandom);
            if (b == 8'hAA) b = 8'h55;
            send_byte(b);
         end
      end
      send_byte(8'hAA);
      send_byte(cmd);
      send_byte(len);
      if (kind == 2) begin
         expect_err("rnd_len", 2'd1);
      end else begin
         chk = cmd ^ len;
         for (int j = 0; j < int'(len); j++) begin
            b = 8'($urandom);
            pl[8*j +: 8] = b;
            chk = chk ^ b;
            send_byte(b);
         end
         if (kind == 1) begin
            send_byte(chk ^ 8'($urandom_range(1, 255)));
            expect_err("rnd_chk", 2'd2);
         end else begin
            send_byte(chk);
            expect_good("rnd_good", cmd, len[3:0], pl);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      ev_t e;
      #1 rst = 1'b1;
      #2;
      check("rst_valid", frame_valid, 0);
      check("rst_err", frame_err, 0);
      check_held("rst");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Directed test 1: good frame with a two-byte payload.
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h30);
      expect_good("t1", 8'h01, 4'd2, 64'h2211);

      // Directed test 2: the checksum should be 01, but 00 is sent.
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      expect_err("t2", 2'd2);

      // Directed test 3: LEN of 9 is too large, then a good zero-length frame follows.
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h09);
      expect_err("t3a", 2'd1);
      send_byte(8'hAA); send_byte(8'h7F); send_byte(8'h00); send_byte(8'h7F);
      expect_good("t3b", 8'h7F, 4'd0, '0);

      // Directed test 4: junk bytes before the header are dropped without an error.
      send_byte(8'h00); send_byte(8'h13);
      send_byte(8'hAA); send_byte(8'h05); send_byte(8'h01); send_byte(8'h44); send_byte(8'h40);
      expect_good("t4", 8'h05, 4'd1, 64'h44);

      // Directed test 5a: silence after CMD causes a timeout 200 cycles after the CMD strobe.
      send_byte(8'hAA);
      rx_data = 8'h05; rx_done = 1'b1;
      @(posedge clk); #1;
      t0 = cyc; rx_done = 1'b0;
      for (int i = 0; i < 300 && ev_q.size() == 0; i++) begin @(posedge clk); #1; end
      check("to_nev", ev_q.size(), 1);
      if (ev_q.size() > 0) begin
         e = ev_q.pop_front();
         check("to_kind", e.is_err, 1);
         check("to_ecode", e.code, 2'd3);
         check("to_cyc", e.cyc - t0, 200);
      end
      m_code = 2'd3;
      check_held("to");
      ev_q.delete();

      // Directed test 5b: the next strobe lands exactly on the limit cycle, so the byte is accepted.
      send_byte(8'hAA);
      rx_data = 8'h05; rx_done = 1'b1;
      @(posedge clk); #1;
      t0 = cyc; rx_done = 1'b0;
      while (cyc < t0 + 199) begin @(posedge clk); #1; end
      rx_data = 8'h00; rx_done = 1'b1;
      @(posedge clk); #1;
      last_stb = cyc;
      rx_done = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("bnd_noev", ev_q.size(), 0);
      check("bnd_busy", busy, 1'b1);
      send_byte(8'h05);
      expect_good("bnd", 8'h05, 4'd0, '0);

      // Directed test 6: reset mid-frame while rx_done is held high.
      send_byte(8'hAA); send_byte(8'h01);
      rx_data = 8'h03; rx_done = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      #2;
      m_cmd = '0; m_len = '0; m_pl = '0; m_code = '0;
      check("mrst_valid", frame_valid, 0);
      check("mrst_err", frame_err, 0);
      check_held("mrst");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      check("mrst_busy", busy, 1'b0);
      check("mrst_noev", ev_q.size(), 0);
      rx_done = 1'b0;
      @(posedge clk); #1;
      random_frame(0);

      // Random frames.
      for (int n = 0; n < 40; n++) random_frame($urandom_range(0, 3));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
